// File: rtl/matrix_row_accumulator_if.sv
// Bus between the element-wise multiplier and the row accumulator: the start
// request, the flat product array, and the registered result/status.
interface matrix_row_accumulator_if #(
  parameter int MATRIX_WIDTH  = 5,
  parameter int MATRIX_HEIGHT = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int ACC_WIDTH     = 11,
  parameter int MATRIX_SIZE   = MATRIX_WIDTH * MATRIX_HEIGHT * DATA_WIDTH,
  parameter int RESULT_SIZE   = MATRIX_HEIGHT * ACC_WIDTH
) ();

  // Handshake: i_start is edge-triggered (a rising edge requests one computation,
  // a held level requests nothing further); i_products is captured on that edge
  // only. o_ready is a one-cycle strobe marking o_result as newly valid; o_result
  // then holds until the next completion or reset. There is no back-pressure.
  logic                   i_start;
  logic [MATRIX_SIZE-1:0] i_products;
  logic [RESULT_SIZE-1:0] o_result;
  logic                   o_busy;
  logic                   o_ready;
  logic [1:0]             o_state;

  modport master (
    output i_start,
    output i_products,
    input  o_result,
    input  o_busy,
    input  o_ready,
    input  o_state
  );

  modport slave (
    input  i_start,
    input  i_products,
    output o_result,
    output o_busy,
    output o_ready,
    output o_state
  );

endinterface

// File: rtl/matrix_row_accumulator.sv
// Sums each row of a captured product matrix, one element per clock through a
// single adder, and publishes the whole row-sum vector at once.
module matrix_row_accumulator #(
  parameter int MATRIX_WIDTH  = 5,
  parameter int MATRIX_HEIGHT = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int ACC_WIDTH     = 11,
  parameter int MATRIX_SIZE   = MATRIX_WIDTH * MATRIX_HEIGHT * DATA_WIDTH,
  parameter int RESULT_SIZE   = MATRIX_HEIGHT * ACC_WIDTH
) (
  input logic                      clk,
  input logic                      i_rst,
  matrix_row_accumulator_if.slave  bus
);

  localparam int NUM_ELEMS = MATRIX_WIDTH * MATRIX_HEIGHT;
  localparam int IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam int ROW_W     = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
  localparam int COL_W     = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state;
  logic                  start_q;
  logic [DATA_WIDTH-1:0] snap    [NUM_ELEMS];
  logic [ACC_WIDTH-1:0]  row_buf [MATRIX_HEIGHT];
  logic [IDX_W-1:0]      idx;
  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic [ACC_WIDTH-1:0]  acc;

  logic                   start_rise;
  logic [DATA_WIDTH-1:0]  elem;
  logic [ACC_WIDTH-1:0]   sum;
  logic                   last_col;
  logic                   last_row;
  logic [RESULT_SIZE-1:0] result_next;

  assign start_rise = bus.i_start & ~start_q;
  assign last_col   = (col == COL_W'(MATRIX_WIDTH - 1));
  assign last_row   = (row == ROW_W'(MATRIX_HEIGHT - 1));
  assign bus.o_state = state;

  // idx walks the snapshot linearly (row-major), so no row*width multiply is needed.
  always_comb begin
    elem = snap[idx];
    sum  = acc + ACC_WIDTH'(elem);
  end

  // The completed vector must include the row being finished this cycle,
  // so the final row comes straight from the adder rather than row_buf.
  always_comb begin
    result_next = '0;
    for (int i = 0; i < MATRIX_HEIGHT; i++) begin
      result_next[i*ACC_WIDTH +: ACC_WIDTH] = (ROW_W'(i) == row) ? sum : row_buf[i];
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      idx          <= '0;
      row          <= '0;
      col          <= '0;
      acc          <= '0;
      bus.o_result <= '0;
      bus.o_busy   <= 1'b0;
      bus.o_ready  <= 1'b0;
      for (int i = 0; i < NUM_ELEMS; i++) snap[i] <= '0;
      for (int i = 0; i < MATRIX_HEIGHT; i++) row_buf[i] <= '0;
    end else begin
      start_q <= bus.i_start;
      case (state)
        S_IDLE: begin
          bus.o_ready <= 1'b0;
          if (start_rise) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
              snap[i] <= bus.i_products[i*DATA_WIDTH +: DATA_WIDTH];
            end
            idx        <= '0;
            row        <= '0;
            col        <= '0;
            acc        <= '0;
            bus.o_busy <= 1'b1;
            state      <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          idx <= idx + 1'b1;
          if (!last_col) begin
            acc <= sum;
            col <= col + 1'b1;
          end else begin
            row_buf[row] <= sum;
            acc          <= '0;
            col          <= '0;
            if (last_row) begin
              bus.o_result <= result_next;
              bus.o_ready  <= 1'b1;
              bus.o_busy   <= 1'b0;
              state        <= S_DONE;
            end else begin
              row <= row + 1'b1;
            end
          end
        end

        // A start edge arriving here is deliberately dropped, not queued.
        S_DONE: begin
          bus.o_ready <= 1'b0;
          state       <= S_IDLE;
        end

        default: begin
          bus.o_ready <= 1'b0;
          bus.o_busy  <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
